// File: rtl/ibert_mem_pkg.sv
// Shared definitions for the ping-pong buffer read-side address generators.
// Holds the read FSM state type and the block credit limits.
package ibert_mem_pkg;

  // Read FSM: IDLE waits for a written block, READ issues bank addresses.
  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  // Written-but-unread block credit: 0..2 (one per buffer half).
  localparam int                  CREDIT_W   = 2;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = 2'd2;
  localparam logic [CREDIT_W-1:0] CREDIT_ONE = 2'd1;

endpackage

// File: rtl/delay_line.sv
// Fixed-latency shift register, WIDTH bits wide and DEPTH stages deep.
// Used to align bank-read strobes and markers with the bank read latency.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift din through DEPTH registered stages.
  // NOTE: this array is a handful of strobe flops, not a RAM, so it is reset;
  // a reset must flush any in-flight valid bits rather than let them emerge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/mem_read_b_pp.sv
// Read-side address generator for the ping-pong B buffer.
// Issues one lock-step address to all N2 banks per accepted cycle, walking
// row / phase / repeat / block, alternating buffer halves per block and
// tracking written-but-unread blocks with a 2-deep credit counter.
// Optional feature: define MEM_READ_B_TILE_MARK_EN to generate tile_first /
// tile_last; otherwise they are tied low and their pipeline is absent.
module mem_read_b_pp
  import ibert_mem_pkg::*;
#(
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12,
  parameter int RD_LAT       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTHdN2,
  input  logic [MATRIXSIZE_W-1:0] BLOCK_NUM,
  input  logic [MATRIXSIZE_W-1:0] REPEAT,
  input  logic                    blk_wr_done,
  input  logic                    rd_ready,
  output logic [ADDR_W-1:0]       rd_addr_B,
  output logic                    rd_en_B,
  output logic                    data_valid_B,
  output logic                    tile_first,
  output logic                    tile_last,
  output logic                    blk_rd_done,
  output logic                    all_done,
  output logic                    overflow_err
);

  localparam logic [MATRIXSIZE_W-1:0] CNT_ONE = MATRIXSIZE_W'(1);

  if (N2 < 1 || RD_LAT < 1) begin : g_param_check
    $error("mem_read_b_pp: N2 and RD_LAT must be at least 1");
  end

  rd_state_e               state;
  logic [MATRIXSIZE_W-1:0] row, phase, rep, blk_cnt;
  logic [ADDR_W-2:0]       offset;     // phase*M2, accumulated
  logic                    pp;         // buffer half being read
  logic [CREDIT_W-1:0]     credit, credit_nxt;
  logic                    ovf_set;
  logic                    issue, row_last, phase_last, rep_last, blk_last, blk_end;
  logic [ADDR_W-1:0]       addr;

  // Loop-position decode and the address for the current issue.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    issue      = (state == READ) && rd_ready;
    row_last   = (row     == M2 - CNT_ONE);
    phase_last = (phase   == BLOCK_WIDTHdN2 - CNT_ONE);
    rep_last   = (rep     == REPEAT - CNT_ONE);
    blk_last   = (blk_cnt == BLOCK_NUM - CNT_ONE);
    blk_end    = issue && row_last && phase_last && rep_last;
    addr       = {pp, offset + row[ADDR_W-2:0]};
  end

  // Credit update: writer completions add, block ends remove, both cancel.
  always_comb begin
    credit_nxt = credit;
    ovf_set    = 1'b0;
    if (blk_wr_done && !blk_end) begin
      if (credit == CREDIT_MAX) ovf_set    = 1'b1;
      else                      credit_nxt = credit + CREDIT_ONE;
    end else if (!blk_wr_done && blk_end) begin
      credit_nxt = credit - CREDIT_ONE;
    end
  end

  // Read FSM, loop counters, credit and registered read-side outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      phase        <= '0;
      rep          <= '0;
      blk_cnt      <= '0;
      offset       <= '0;
      pp           <= 1'b0;
      credit       <= '0;
      overflow_err <= 1'b0;
      rd_addr_B    <= '0;
      rd_en_B      <= 1'b0;
      blk_rd_done  <= 1'b0;
      all_done     <= 1'b0;
    end else begin
      credit      <= credit_nxt;
      rd_en_B     <= issue;
      blk_rd_done <= blk_end;
      all_done    <= blk_end && blk_last;
      if (ovf_set) overflow_err <= 1'b1;

      if (issue) begin
        rd_addr_B <= addr;
        if (!row_last) begin
          row <= row + CNT_ONE;
        end else begin
          row <= '0;
          if (!phase_last) begin
            phase  <= phase + CNT_ONE;
            offset <= offset + M2[ADDR_W-2:0];
          end else begin
            phase  <= '0;
            offset <= '0;
            if (!rep_last) begin
              rep <= rep + CNT_ONE;
            end else begin
              rep     <= '0;
              pp      <= ~pp;
              blk_cnt <= blk_last ? '0 : blk_cnt + CNT_ONE;
            end
          end
        end
      end

      case (state)
        IDLE: if (credit_nxt != '0) state <= READ;
        READ: if (blk_end && (blk_last || credit_nxt == '0)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_READ_B_TILE_MARK_EN
  logic       mark_first_q, mark_last_q;
  logic [2:0] dly_out;

  // Row markers registered alongside rd_en_B, then delayed with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mark_first_q <= 1'b0;
      mark_last_q  <= 1'b0;
    end else begin
      mark_first_q <= issue && (row == '0);
      mark_last_q  <= issue && row_last;
    end
  end

  delay_line #(.WIDTH(3), .DEPTH(RD_LAT)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_en_B, mark_first_q, mark_last_q}),
    .dout (dly_out)
  );

  assign data_valid_B = dly_out[2];
  assign tile_first   = dly_out[1];
  assign tile_last    = dly_out[0];
`else
  delay_line #(.WIDTH(1), .DEPTH(RD_LAT)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_en_B),
    .dout (data_valid_B)
  );

  assign tile_first = 1'b0;
  assign tile_last  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_read_b_pp.sv
// Self-checking bench for mem_read_b_pp: a cycle table for a single block,
// directed multi-cycle sequences, and randomized traffic against a
// block/row/phase reference model.
module tb_mem_read_b_pp;

  localparam int ADDR_W = 12;
  localparam int MSW    = 16;
  localparam int HALF   = 2048;
`ifdef MEM_READ_B_TILE_MARK_EN
  localparam bit MARK_EN = 1'b1;
`else
  localparam bit MARK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [MSW-1:0]    M2, BLOCK_WIDTHdN2, BLOCK_NUM, REPEAT;
  logic              blk_wr_done, rd_ready;
  logic [ADDR_W-1:0] rd_addr_B;
  logic              rd_en_B, data_valid_B, tile_first, tile_last;
  logic              blk_rd_done, all_done, overflow_err;

  mem_read_b_pp #(.N2(4), .MATRIXSIZE_W(MSW), .ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .M2(M2), .BLOCK_WIDTHdN2(BLOCK_WIDTHdN2),
    .BLOCK_NUM(BLOCK_NUM), .REPEAT(REPEAT), .blk_wr_done(blk_wr_done),
    .rd_ready(rd_ready), .rd_addr_B(rd_addr_B), .rd_en_B(rd_en_B),
    .data_valid_B(data_valid_B), .tile_first(tile_first), .tile_last(tile_last),
    .blk_rd_done(blk_rd_done), .all_done(all_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    blk_wr_done = 1'b0;
    rd_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // ---------------- issue log for the directed sequences ----------------
  typedef struct {
    int addr;
    bit bd;
    bit ad;
  } iss_t;

  iss_t got_q[$];
  iss_t exp_q[$];
  int   tick_n, first_en, last_en, stray_n;

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    tick_n = 0; first_en = -1; last_en = -1; stray_n = 0;
  endtask

  task automatic tick();
    iss_t e;
    step();
    tick_n++;
    if (rd_en_B) begin
      e.addr = int'(rd_addr_B); e.bd = blk_rd_done; e.ad = all_done;
      got_q.push_back(e);
      if (first_en < 0) first_en = tick_n;
      last_en = tick_n;
    end else if (blk_rd_done || all_done) begin
      stray_n++;
    end
  endtask

  // Expected block: all phases of a block in half pp, REPEAT times.
  task automatic push_block(input int pp, input int m2, input int bw, input int reps,
                            input bit is_final);
    iss_t e;
    for (int r = 0; r < reps; r++)
      for (int ph = 0; ph < bw; ph++)
        for (int rw = 0; rw < m2; rw++) begin
          e.addr = pp * HALF + ph * m2 + rw;
          e.bd   = (r == reps - 1) && (ph == bw - 1) && (rw == m2 - 1);
          e.ad   = e.bd && is_final;
          exp_q.push_back(e);
        end
  endtask

  task automatic compare_issued(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_bd%0d", tag, i), int'(got_q[i].bd), int'(exp_q[i].bd));
      check($sformatf("%s_ad%0d", tag, i), int'(got_q[i].ad), int'(exp_q[i].ad));
    end
    check({tag, "_stray_done"}, stray_n, 0);
  endtask

  // ---------------- single-block cycle table ----------------
  typedef struct {
    bit wr, rdy;
    bit en; int addr; bit bd, ad, dv, tf, tl;
  } vec_t;

  vec_t vt[9];

  // ---------------- randomized reference model ----------------
  int m_pulses, m_blk, m_idx;
  bit p_en, p_first, p_last;

  task automatic rand_cycle(input bit traffic);
    int m2, bw, reps, bn, total, rw, ph, exp_addr;
    bit prev_rdy, last;
    m2 = int'(M2); bw = int'(BLOCK_WIDTHdN2); reps = int'(REPEAT); bn = int'(BLOCK_NUM);
    rd_ready    = traffic ? ($urandom_range(0, 3) != 0) : 1'b1;
    blk_wr_done = traffic && (m_pulses - m_blk < 2) && ($urandom_range(0, 7) == 0);
    if (blk_wr_done) m_pulses++;
    prev_rdy = rd_ready;
    step();
    check("rnd_en_without_ready", int'(rd_en_B && !prev_rdy), 0);
    check("rnd_data_valid", int'(data_valid_B), int'(p_en));
    check("rnd_tile_first", int'(tile_first), int'(p_en && p_first && MARK_EN));
    check("rnd_tile_last", int'(tile_last), int'(p_en && p_last && MARK_EN));
    p_en = rd_en_B; p_first = 1'b0; p_last = 1'b0;
    if (rd_en_B) begin
      total    = m2 * bw * reps;
      rw       = m_idx % m2;
      ph       = (m_idx / m2) % bw;
      exp_addr = (m_blk % 2) * HALF + ph * m2 + rw;
      last     = (m_idx == total - 1);
      check("rnd_read_without_credit", int'(m_blk >= m_pulses), 0);
      check("rnd_addr", int'(rd_addr_B), exp_addr);
      check("rnd_blk_rd_done", int'(blk_rd_done), int'(last));
      check("rnd_all_done", int'(all_done), int'(last && (m_blk % bn == bn - 1)));
      p_first = (rw == 0);
      p_last  = (rw == m2 - 1);
      if (last) begin m_idx = 0; m_blk++; end
      else m_idx++;
    end else begin
      check("rnd_stray_done", int'(blk_rd_done || all_done), 0);
    end
  endtask

  initial begin
    rst = 1'b1; blk_wr_done = 1'b0; rd_ready = 1'b0;
    M2 = 16'd3; BLOCK_WIDTHdN2 = 16'd2; BLOCK_NUM = 16'd2; REPEAT = 16'd1;

    // Reset state
    repeat (2) step();
    check("rst_rd_en", int'(rd_en_B), 0);
    check("rst_addr", int'(rd_addr_B), 0);
    check("rst_blk_rd_done", int'(blk_rd_done), 0);
    check("rst_all_done", int'(all_done), 0);
    check("rst_data_valid", int'(data_valid_B), 0);
    check("rst_tile_first", int'(tile_first), 0);
    check("rst_tile_last", int'(tile_last), 0);
    check("rst_overflow", int'(overflow_err), 0);
    rst = 1'b0;

    // Single block, one row per cycle: inputs of cycle k, outputs after its edge
    vt[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    vt[2] = '{0, 1, 1, 1, 0, 0, 1, 1, 0};
    vt[3] = '{0, 1, 1, 2, 0, 0, 1, 0, 0};
    vt[4] = '{0, 1, 1, 3, 0, 0, 1, 0, 1};
    vt[5] = '{0, 1, 1, 4, 0, 0, 1, 1, 0};
    vt[6] = '{0, 1, 1, 5, 1, 0, 1, 0, 0};
    vt[7] = '{0, 1, 0, 5, 0, 0, 1, 0, 1};
    vt[8] = '{0, 1, 0, 5, 0, 0, 0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      blk_wr_done = vt[k].wr;
      rd_ready    = vt[k].rdy;
      step();
      check($sformatf("vec%0d_en", k), int'(rd_en_B), int'(vt[k].en));
      check($sformatf("vec%0d_addr", k), int'(rd_addr_B), vt[k].addr);
      check($sformatf("vec%0d_bd", k), int'(blk_rd_done), int'(vt[k].bd));
      check($sformatf("vec%0d_ad", k), int'(all_done), int'(vt[k].ad));
      check($sformatf("vec%0d_dv", k), int'(data_valid_B), int'(vt[k].dv));
      check($sformatf("vec%0d_tf", k), int'(tile_first), int'(vt[k].tf && MARK_EN));
      check($sformatf("vec%0d_tl", k), int'(tile_last), int'(vt[k].tl && MARK_EN));
    end
    blk_wr_done = 1'b0;

    // Back-to-back ping-pong: two blocks, no bubble, all_done on the last
    do_reset();
    clear_logs();
    blk_wr_done = 1'b1; rd_ready = 1'b1;
    tick(); tick();
    blk_wr_done = 1'b0;
    repeat (16) tick();
    push_block(0, 3, 2, 1, 1'b0);
    push_block(1, 3, 2, 1, 1'b1);
    compare_issued("b2b");
    check("b2b_no_bubble", last_en - first_en + 1, 12);
    check("b2b_credit_empty", int'(dut.credit), 0);

    // Repeat: the block is read twice, one blk_rd_done at the very end
    REPEAT = 16'd2;
    do_reset();
    clear_logs();
    blk_wr_done = 1'b1; rd_ready = 1'b1;
    tick();
    blk_wr_done = 1'b0;
    repeat (20) tick();
    push_block(0, 3, 2, 2, 1'b0);
    compare_issued("repeat");
    REPEAT = 16'd1;

    // Backpressure: rd_ready low 3 cycles after address 1 issues
    do_reset();
    clear_logs();
    blk_wr_done = 1'b1; rd_ready = 1'b1;
    tick();
    blk_wr_done = 1'b0;
    for (int i = 0; i < 10 && got_q.size() < 2; i++) tick();
    check("bp_reached_addr1", got_q.size(), 2);
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_stall%0d_en", i), int'(rd_en_B), 0);
      check($sformatf("bp_stall%0d_addr_hold", i), int'(rd_addr_B), 1);
    end
    rd_ready = 1'b1;
    repeat (10) tick();
    push_block(0, 3, 2, 1, 1'b0);
    compare_issued("bp");

    // Overflow: credit saturates at 2, error is sticky
    do_reset();
    rd_ready = 1'b0;
    blk_wr_done = 1'b1;
    step(); step();
    check("ovf_credit_two", int'(dut.credit), 2);
    check("ovf_not_yet", int'(overflow_err), 0);
    step();
    blk_wr_done = 1'b0;
    check("ovf_credit_sat", int'(dut.credit), 2);
    check("ovf_set", int'(overflow_err), 1);
    repeat (5) step();
    check("ovf_sticky", int'(overflow_err), 1);
    check("ovf_no_read", int'(rd_en_B), 0);

    // Async reset mid-block, then restart from address 0 in half 0
    do_reset();
    clear_logs();
    blk_wr_done = 1'b1; rd_ready = 1'b1;
    tick();
    blk_wr_done = 1'b0;
    for (int i = 0; i < 10 && got_q.size() < 4; i++) tick();
    check("arst_reached_addr3", got_q.size(), 4);
    #2 rst = 1'b1;
    #1;
    check("arst_en", int'(rd_en_B), 0);
    check("arst_addr", int'(rd_addr_B), 0);
    check("arst_dv", int'(data_valid_B), 0);
    check("arst_tf", int'(tile_first), 0);
    check("arst_bd", int'(blk_rd_done), 0);
    check("arst_credit", int'(dut.credit), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    clear_logs();
    blk_wr_done = 1'b1;
    tick();
    blk_wr_done = 1'b0;
    repeat (12) tick();
    push_block(0, 3, 2, 1, 1'b0);
    compare_issued("arst_restart");

    // Randomized traffic under several configurations
    for (int c = 0; c < 3; c++) begin
      M2             = MSW'($urandom_range(1, 4));
      BLOCK_WIDTHdN2 = MSW'($urandom_range(1, 3));
      REPEAT         = MSW'($urandom_range(1, 2));
      BLOCK_NUM      = MSW'($urandom_range(1, 3));
      do_reset();
      m_pulses = 0; m_blk = 0; m_idx = 0;
      p_en = 1'b0; p_first = 1'b0; p_last = 1'b0;
      repeat (400) rand_cycle(1'b1);
      for (int i = 0; i < 500 && (m_blk < m_pulses || rd_en_B); i++) rand_cycle(1'b0);
      check($sformatf("rnd%0d_all_blocks_read", c), m_blk, m_pulses);
      check($sformatf("rnd%0d_mid_block", c), m_idx, 0);
      check($sformatf("rnd%0d_no_overflow", c), int'(overflow_err), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
